seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
Multi-cycle signed integer divider, the inverse operation of the team's combinational signed multiplier. It takes a WIDTH-bit signed dividend and divisor and returns a truncated quotient and remainder. It uses a radix-2 restoring algorithm on magnitudes, followed by sign correction. It uses a start/busy/done handshake so datapath control can issue divides and collect results.

Parameters:
WIDTH, 32, operand/result width in bits (signed two's complement; minimum 4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
A  input  WIDTH  signed dividend, sampled on accepting edge
B  input  WIDTH  signed divisor, sampled on accepting edge
busy  output  1  operation in progress
done  output  1  one-cycle pulse: Q/R/flags valid
Q  output  WIDTH  signed quotient
R  output  WIDTH  signed remainder
div_by_zero  output  1  last result had B=0
overflow  output  1  last result was most-negative / -1

Behaviour:
- Interface: one clock domain, clk. Reset rst_n is asynchronous, active-low; all state clears immediately on assertion.
- Reset values: busy=0, done=0, Q=0, R=0, div_by_zero=0, overflow=0, state=IDLE, iteration counter=0.
- FSM states: IDLE, CALC, FIX.
- IDLE: on an edge with start=1, register A, B, |A|, |B|, sign_q=A[MSB]^B[MSB] and sign_r=A[MSB].
  - Clear the partial remainder and load the quotient shift register with |A|.
  - Go to CALC with count=0 and set busy=1.
- CALC: one iteration per cycle, exactly WIDTH cycles.
  - Shift {rem,quo} left by 1 and trial-subtract |B|.
  - If the result is non-negative, keep it and set quo[0]=1; otherwise restore and set quo[0]=0.
  - The partial remainder is WIDTH+1 bits wide so that |A|=2^(WIDTH-1) works.
  - After iteration WIDTH, go to FIX.
- FIX: apply signs and write the outputs.
  - Q = sign_q ? -quo : quo.
  - R = sign_r ? -rem : rem.
  - Set done=1 and busy=0, and return to IDLE.
- Latency: constant. done is high in the cycle following the edge that lies WIDTH+1 edges after the accepting edge (33 cycles for WIDTH=32), including the special cases.
- Rounding: truncate toward zero. R takes the sign of A. A = Q*B + R and |R| < |B| hold for all non-special cases.
- Divide by zero (B=0): Q = all ones (-1), R = A, div_by_zero=1, overflow=0.
- Overflow (A = -2^(WIDTH-1), B = -1): Q = -2^(WIDTH-1), R = 0, overflow=1, div_by_zero=0.
- Flags are cleared on every normal result and updated only together with done.
- done is high for exactly one cycle. Q, R and the flags hold their values until the next done or reset.
- start while busy=1: ignored. The in-flight operation and its operands are unaffected.
- start is accepted in the same cycle that done=1 (busy=0 then). This allows back-to-back operation with no idle cycle.
- A and B may change freely after the accepting edge.
- Reset mid-operation: abort immediately, return to the reset values above, and produce no done pulse.

Test Plan:
- A=17, B=-5, start pulse -> done exactly 33 cycles later; Q=-3 (FFFFFFFD), R=2, flags 0; busy high throughout the interval.
- A=-17, B=5 -> Q=-3, R=-2. A=-50, B=-5 -> Q=10, R=0. A=0, B=10 -> Q=0, R=0. A=10, B=1 -> Q=10, R=0.
- A=25, B=0 -> Q=FFFFFFFF, R=25, div_by_zero=1, same 33-cycle latency. A=80000000, B=FFFFFFFF -> Q=80000000, R=0, overflow=1.
- Back-to-back and busy-ignore:
  - Issue 100/7, with start re-asserted mid-run carrying 9/3 -> first result Q=14, R=2, second request ignored.
  - Then start in the done cycle with 9/3 -> Q=3, R=0, done 33 cycles later.
- Reset mid-operation: assert rst_n=0 at cycle 10 of a divide -> all outputs 0 immediately, and no done after release. A new start then divides correctly.
- Randomized sweep (1000 pairs, B≠0, excluding the overflow pair) -> Q*B+R == A, |R|<|B|, and sign(R) equals sign(A) whenever R≠0.

Source files
------------

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_signed_divider
// Description : Multi-cycle signed integer divider. Radix-2 restoring
//               division on operand magnitudes, then sign correction.
//               start/busy/done handshake, constant WIDTH+1 cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int                 c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q;
    logic [c_CNT_W-1:0] count_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   absb_q;
    logic [WIDTH-1:0]   quo_q;
    // One bit wider than the operands so a dividend magnitude of 2^(WIDTH-1)
    // never loses its top bit while being shifted in.
    logic [WIDTH:0]     rem_q;
    logic               sign_q_q;
    logic               sign_r_q;

    logic [WIDTH-1:0]   absa_d;
    logic [WIDTH-1:0]   absb_d;
    logic [WIDTH+1:0]   trial_d;
    logic [WIDTH:0]     rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_mag_d;
    logic [WIDTH-1:0]   q_fix_d;
    logic [WIDTH-1:0]   r_fix_d;
    logic               dbz_d;
    logic               ovf_d;

    // Operand magnitudes, one restoring step, and the sign-corrected result.
    always_comb begin
        // The most-negative value negates to itself, which read as unsigned
        // is exactly its magnitude 2^(WIDTH-1).
        absa_d = A[WIDTH-1] ? -A : A;
        absb_d = B[WIDTH-1] ? -B : B;

        // Shift {rem,quo} left by one and trial-subtract |B|; the extra top
        // bit of the difference is the borrow that says "restore".
        trial_d = {rem_q, quo_q[WIDTH-1]} - {2'b00, absb_q};
        if (!trial_d[WIDTH+1]) begin
            rem_d = trial_d[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end

        // The final remainder is below |B| <= 2^(WIDTH-1), so WIDTH bits hold it.
        rem_mag_d = rem_q[WIDTH-1:0];
        dbz_d     = (b_q == '0);
        ovf_d     = !dbz_d && (a_q == c_MOST_NEG) && (b_q == '1);

        if (dbz_d) begin
            q_fix_d = '1;
            r_fix_d = a_q;
        end else if (ovf_d) begin
            q_fix_d = c_MOST_NEG;
            r_fix_d = '0;
        end else begin
            q_fix_d = sign_q_q ? -quo_q : quo_q;
            r_fix_d = sign_r_q ? -rem_mag_d : rem_mag_d;
        end
    end

    // Control FSM plus datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            absb_q      <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        absb_q   <= absb_d;
                        quo_q    <= absa_d;
                        rem_q    <= '0;
                        sign_q_q <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r_q <= A[WIDTH-1];
                        count_q  <= '0;
                        busy     <= 1'b1;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + c_CNT_W'(1);
                    if (count_q == c_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    Q           <= q_fix_d;
                    R           <= r_fix_d;
                    div_by_zero <= dbz_d;
                    overflow    <= ovf_d;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_signed_divider
// Description : Self-checking bench for seq_signed_divider. Expected results
//               are queued when a request is accepted and compared when done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_signed_divider;

    localparam int               W     = 32;
    localparam logic [W-1:0]     c_MIN = {1'b1, {(W-1){1'b0}}};

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int unsigned  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         div_by_zero;
    logic         overflow;

    exp_t         sb[$];
    int unsigned  cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: SystemVerilog signed / and % truncate toward zero.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a; e.b = b; e.cyc = 0; e.dbz = 1'b0; e.ovf = 1'b0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1;
        end else if (a == c_MIN && b == '1) begin
            e.q = c_MIN; e.r = '0; e.ovf = 1'b1;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end
        return e;
    endfunction

    // Drive a request at the current negedge; queue its expectation if accepted.
    task automatic issue_now(input logic [W-1:0] a, input logic [W-1:0] b, output logic acc);
        exp_t e;
        start = 1'b1; A = a; B = b;
        acc = !busy;
        e = model(a, b);
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom; B = $urandom;
        if (acc) begin
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output logic acc);
        @(negedge clk);
        issue_now(a, b, acc);
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            check(tag, 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Scoreboard: compare each done pulse against the oldest expectation.
    initial begin : monitor
        exp_t   e;
        longint la, lb, lq, lr;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("Q", 64'(Q), 64'(e.q));
                    check("R", 64'(R), 64'(e.r));
                    check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    check("overflow", 64'(overflow), 64'(e.ovf));
                    check("latency", 64'(cyc - e.cyc), 64'(W + 1));
                    check("busy_at_done", 64'(busy), 64'd0);
                    if (!e.dbz && !e.ovf) begin
                        la = $signed(e.a); lb = $signed(e.b);
                        lq = $signed(Q);   lr = $signed(R);
                        check("identity", 64'(lq * lb + lr), 64'(la));
                        check("rem_below_div", 64'((lr < 0 ? -lr : lr) < (lb < 0 ? -lb : lb)), 64'd1);
                        if (lr != 0) check("rem_sign", 64'(R[W-1]), 64'(e.a[W-1]));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic         acc;
        int           bad;
        logic         seen;
        logic [W-1:0] ra, rb;
        logic [W-1:0] da[9] = '{32'd17, -32'sd17, -32'sd50, 32'd0, 32'd10, 32'd25, c_MIN, c_MIN, 32'd7};
        logic [W-1:0] db[9] = '{-32'sd5, 32'd5, -32'sd5, 32'd10, 32'd1, 32'd0, '1, 32'd1, c_MIN};

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, Q, R, div_by_zero, overflow}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 17 / -5 with busy held across the whole interval.
        issue(da[0], db[0], acc);
        bad = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (!busy || done) bad++;
        end
        check("busy_window", 64'(bad), 64'd0);
        drain("drain_first");
        repeat (5) @(negedge clk);
        check("Q_holds", 64'(Q), 64'(32'hFFFF_FFFD));

        for (int i = 1; i < 9; i++) begin
            issue(da[i], db[i], acc);
            drain("drain_directed");
        end

        // start while busy is ignored; start in the done cycle is accepted.
        issue(32'd100, 32'd7, acc);
        repeat (10) @(negedge clk);
        issue_now(32'd9, 32'd3, acc);
        check("ignored_while_busy", 64'(acc), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("first_done_seen", 64'(seen), 64'd1);
        issue_now(32'd9, 32'd3, acc);
        check("accept_in_done_cycle", 64'(acc), 64'd1);
        drain("drain_b2b");

        // Reset in the middle of an operation.
        issue(32'd200, 32'd7, acc);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("reset_mid_op", 64'({busy, done, Q, R, div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        issue(32'd1000, -32'sd3, acc);
        drain("drain_after_reset");

        // Randomized sweep, divisor never zero and never the overflow pair.
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom_range(1, 20);
                1: rb = -$urandom_range(1, 20);
                2: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (n % 50 == 0) ra = c_MIN;
            if (rb == '0) rb = 32'd1;
            if (ra == c_MIN && rb == '1) rb = 32'd2;
            issue(ra, rb, acc);
            drain("drain_random");
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
